// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
// Shared constants and types for the 480x272 parallel-RGB raster timing path.
// Holds the default panel timing for the 4.3" display, the derived line/frame
// totals, counter and coordinate widths, sync polarities and the phase type
// that each timing axis reports.
package lcd_timing_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int H_ACTIVE_DEF = 480;
    localparam int H_FP_DEF     = 2;
    localparam int H_SYNC_DEF   = 41;
    localparam int H_BP_DEF     = 2;

    // Default vertical timing, in lines
    localparam int V_ACTIVE_DEF = 272;
    localparam int V_FP_DEF     = 2;
    localparam int V_SYNC_DEF   = 10;
    localparam int V_BP_DEF     = 2;

    // Sync levels while the pulse is asserted (0 = active-low)
    localparam bit HS_POL_DEF = 1'b0;
    localparam bit VS_POL_DEF = 1'b0;

    // Widths of the raster counters, the exported coordinates and the frame counter
    localparam int CNT_W   = 10;
    localparam int COORD_W = 9;
    localparam int FRAME_W = 8;

    // Length of one axis period: active, front porch, sync, back porch
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef logic [CNT_W-1:0] cnt_t;

    // Where a counter currently sits within its axis period
    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

endpackage

// File: rtl/lcd_timing_if.sv
// lcd_timing_if
// Bundle of the registered raster outputs that feed the colour stage and the
// LCD pins.
//   hsync_o / vsync_o : sync pulses at the configured polarity
//   den_o             : data enable, high in the visible area only
//   col_o / lin_o     : visible pixel coordinates, 0 outside the visible area
//   sof_o             : one-clock strobe with pixel (0,0)
//   frame_o           : free-running frame counter
// master: the timing generator drives the bundle; slave: downstream consumers.
interface lcd_timing_if;
    import lcd_timing_pkg::*;

    logic               hsync_o;
    logic               vsync_o;
    logic               den_o;
    logic [COORD_W-1:0] col_o;
    logic [COORD_W-1:0] lin_o;
    logic               sof_o;
    logic [FRAME_W-1:0] frame_o;

    modport master (
        output hsync_o, vsync_o, den_o, col_o, lin_o, sof_o, frame_o
    );

    modport slave (
        input hsync_o, vsync_o, den_o, col_o, lin_o, sof_o, frame_o
    );

endinterface

// File: rtl/lcd_timing_axis.sv
// timing_axis
// One raster axis: a wrapping counter over ACTIVE+FP+SYNC+BP positions and the
// decode of which phase the current count lies in.
//   clk, rst_n : clock and asynchronous active-low reset
//   advance    : step the counter this clock (wraps to 0 after the last position)
//   clear      : force the counter to 0; takes priority over advance
//   cnt        : current position
//   phase      : active / front porch / sync / back porch for cnt
module timing_axis
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   advance,
    input  logic   clear,
    output cnt_t   cnt,
    output phase_t phase
);

    localparam cnt_t LAST       = cnt_t'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
    localparam cnt_t ACTIVE_END = cnt_t'(ACTIVE);
    localparam cnt_t SYNC_START = cnt_t'(ACTIVE + FP);
    localparam cnt_t SYNC_END   = cnt_t'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= (cnt == LAST) ? '0 : cnt + cnt_t'(1);
        end
    end

    // Phases follow each other in increasing count order, so ordered
    // less-than tests pick out the window cnt falls in.
    always_comb begin
        phase = PH_BP;
        if (cnt < ACTIVE_END) begin
            phase = PH_ACTIVE;
        end else if (cnt < SYNC_START) begin
            phase = PH_FP;
        end else if (cnt < SYNC_END) begin
            phase = PH_SYNC;
        end
    end

endmodule

// File: rtl/lcd_timing.sv
// lcd_timing
// Pixel-clock-synchronous raster timing generator for the 480x272 LCD path.
//   pxclk_i   : pixel clock
//   rst_n_i   : asynchronous active-low reset
//   restart_i : synchronous request to restart the raster at pixel (0,0)
//   lcd       : registered sync/enable/coordinate/frame outputs (master side)
// Every output is registered from the counter state before the edge, so all
// pins carry the same one-clock latency relative to the counters.
module lcd_timing
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = HS_POL_DEF,
    parameter bit VS_POL   = VS_POL_DEF
) (
    input  logic         pxclk_i,
    input  logic         rst_n_i,
    input  logic         restart_i,
    lcd_timing_if.master lcd
);

    localparam int   H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int   V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);

    // Coordinates leave on 9 bits and the counters are 10 bits wide
    if (H_ACTIVE > 511 || V_ACTIVE > 511) begin : g_active_check
        $error("lcd_timing: H_ACTIVE and V_ACTIVE must not exceed 511");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
        $error("lcd_timing: H_TOTAL and V_TOTAL must fit the 10-bit counters");
    end

    cnt_t   h_cnt;
    cnt_t   v_cnt;
    phase_t h_phase;
    phase_t v_phase;
    logic   h_wrap;
    logic   den_next;
    logic   sof_next;

    // The line counter steps only on the edge where the pixel counter wraps.
    // restart_i clears both axes, and because clear beats advance a restart on
    // a wrap edge cannot also step the line counter.
    assign h_wrap = (h_cnt == H_LAST);

    timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk     (pxclk_i),
        .rst_n   (rst_n_i),
        .advance (1'b1),
        .clear   (restart_i),
        .cnt     (h_cnt),
        .phase   (h_phase)
    );

    timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk     (pxclk_i),
        .rst_n   (rst_n_i),
        .advance (h_wrap),
        .clear   (restart_i),
        .cnt     (v_cnt),
        .phase   (v_phase)
    );

    assign den_next = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign sof_next = (h_cnt == '0) && (v_cnt == '0);

    // On a restart edge the outputs drop to their idle levels while the
    // counters are cleared, so the following edge presents pixel (0,0) with
    // sof. The frame counter keeps its value until that sof.
    always_ff @(posedge pxclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lcd.hsync_o <= ~HS_POL;
            lcd.vsync_o <= ~VS_POL;
            lcd.den_o   <= 1'b0;
            lcd.col_o   <= '0;
            lcd.lin_o   <= '0;
            lcd.sof_o   <= 1'b0;
            lcd.frame_o <= '0;
        end else if (restart_i) begin
            lcd.hsync_o <= ~HS_POL;
            lcd.vsync_o <= ~VS_POL;
            lcd.den_o   <= 1'b0;
            lcd.col_o   <= '0;
            lcd.lin_o   <= '0;
            lcd.sof_o   <= 1'b0;
        end else begin
            lcd.hsync_o <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            lcd.vsync_o <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            lcd.den_o   <= den_next;
            lcd.col_o   <= den_next ? h_cnt[COORD_W-1:0] : '0;
            lcd.lin_o   <= den_next ? v_cnt[COORD_W-1:0] : '0;
            lcd.sof_o   <= sof_next;
            if (sof_next) begin
                lcd.frame_o <= lcd.frame_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing.sv
// tb_lcd_timing
// Bench for lcd_timing. A shrunken raster (15x8) is checked every cycle
// against a raster model and pinned with hand-worked values; a second instance
// with the panel defaults has one full line measured.
module tb_lcd_timing;
    import lcd_timing_pkg::*;

    // Shrunken raster: 8+2+3+2 = 15 clocks per line, 4+1+2+1 = 8 lines
    localparam int S_HA  = 8;
    localparam int S_HFP = 2;
    localparam int S_HS  = 3;
    localparam int S_HBP = 2;
    localparam int S_HT  = 15;
    localparam int S_VA  = 4;
    localparam int S_VFP = 1;
    localparam int S_VS  = 2;
    localparam int S_VBP = 1;
    localparam int S_VT  = 8;
    localparam bit S_HSP = 1'b0;
    localparam bit S_VSP = 1'b1;

    logic pxclk        = 1'b0;
    logic rst_n        = 1'b0;
    logic restart      = 1'b0;
    logic restart_full = 1'b0;
    logic chk_en       = 1'b0;

    int total = 0;
    int bad   = 0;

    lcd_timing_if lcd_s();
    lcd_timing_if lcd_f();

    lcd_timing #(
        .H_ACTIVE (S_HA),
        .H_FP     (S_HFP),
        .H_SYNC   (S_HS),
        .H_BP     (S_HBP),
        .V_ACTIVE (S_VA),
        .V_FP     (S_VFP),
        .V_SYNC   (S_VS),
        .V_BP     (S_VBP),
        .HS_POL   (S_HSP),
        .VS_POL   (S_VSP)
    ) dut (
        .pxclk_i   (pxclk),
        .rst_n_i   (rst_n),
        .restart_i (restart),
        .lcd       (lcd_s)
    );

    lcd_timing dut_full (
        .pxclk_i   (pxclk),
        .rst_n_i   (rst_n),
        .restart_i (restart_full),
        .lcd       (lcd_f)
    );

    // Output bundle layout: {hsync, vsync, den, col[8:0], lin[8:0], sof, frame[7:0]}
    logic [29:0] s_out;
    assign s_out = {lcd_s.hsync_o, lcd_s.vsync_o, lcd_s.den_o, lcd_s.col_o,
                    lcd_s.lin_o, lcd_s.sof_o, lcd_s.frame_o};

    // Free-running 100 MHz-style clock; rising edges at 5, 15, 25, ...
    always #5 pxclk = ~pxclk;

    function automatic logic [29:0] packOut(input logic hs, input logic vs,
                                            input logic den, input logic [8:0] col,
                                            input logic [8:0] lin, input logic sof,
                                            input logic [7:0] frm);
        return {hs, vs, den, col, lin, sof, frm};
    endfunction

    // What the pins must show once raster position (h,v) has been registered,
    // given the frame count held before that position.
    function automatic logic [29:0] modelOut(input int h, input int v, input logic [7:0] frm);
        logic       den;
        logic       hs;
        logic       vs;
        logic       sof;
        logic [8:0] col;
        logic [8:0] lin;
        den = (h < S_HA) && (v < S_VA);
        hs  = (h >= S_HA + S_HFP && h < S_HA + S_HFP + S_HS) ? S_HSP : ~S_HSP;
        vs  = (v >= S_VA + S_VFP && v < S_VA + S_VFP + S_VS) ? S_VSP : ~S_VSP;
        sof = (h == 0) && (v == 0);
        col = den ? h[8:0] : 9'd0;
        lin = den ? v[8:0] : 9'd0;
        return packOut(hs, vs, den, col, lin, sof, sof ? frm + 8'd1 : frm);
    endfunction

    // Raster model: m_h/m_v is the position the next rising edge will present.
    // A restart shows idle levels now and rewinds to (0,0) for the next edge.
    int          m_h;
    int          m_v;
    logic [7:0]  m_frame;
    logic [29:0] exp_out;

    always @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            m_h     <= 0;
            m_v     <= 0;
            m_frame <= 8'd0;
            exp_out <= packOut(~S_HSP, ~S_VSP, 1'b0, 9'd0, 9'd0, 1'b0, 8'd0);
        end else if (restart) begin
            m_h     <= 0;
            m_v     <= 0;
            exp_out <= packOut(~S_HSP, ~S_VSP, 1'b0, 9'd0, 9'd0, 1'b0, m_frame);
        end else begin
            exp_out <= modelOut(m_h, m_v, m_frame);
            if (m_h == 0 && m_v == 0) begin
                m_frame <= m_frame + 8'd1;
            end
            m_h <= (m_h == S_HT - 1) ? 0 : m_h + 1;
            if (m_h == S_HT - 1) begin
                m_v <= (m_v == S_VT - 1) ? 0 : m_v + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic restart_v);
        rst_n   = rst_v;
        restart = restart_v;
    endtask

    // Compare the shrunken instance against the model on every falling edge
    always @(negedge pxclk) begin
        if (chk_en) begin
            checkOutput("model", {2'b00, s_out}, {2'b00, exp_out});
        end
    end

    // Wait (at falling edges) until the next edge will present (h,v); v<0 = any line
    task automatic waitModelPos(input int h, input int v, input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (m_h == h && (v < 0 || m_v == v)) begin
                found = 1'b1;
            end else begin
                @(negedge pxclk);
            end
        end
        checkOutput({name, "_reached"}, {31'd0, found}, 32'd1);
    endtask

    // Hold restart for 'hold' edges, expect idle outputs with the frame held,
    // then release and expect sof with exactly one frame increment.
    task automatic restartCheck(input string name, input int hold);
        logic [7:0] frm;
        frm = lcd_s.frame_o;
        for (int i = 0; i < hold; i++) begin
            applyStimulus(1'b1, 1'b1);
            @(negedge pxclk);
            checkOutput({name, "_idle"}, {2'b00, s_out},
                        {2'b00, packOut(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, frm)});
        end
        applyStimulus(1'b1, 1'b0);
        @(negedge pxclk);
        checkOutput({name, "_sof"}, {2'b00, s_out},
                    {2'b00, packOut(1'b1, 1'b0, 1'b1, 9'd0, 9'd0, 1'b1, frm + 8'd1)});
    endtask

    initial begin
        int         den_cnt;
        int         hs_cnt;
        int         first_hs;
        int         rise1;
        int         rise2;
        logic       prev_den;
        logic       found;
        int         s_den;
        int         s_sof;

        applyStimulus(1'b0, 1'b0);
        repeat (10) @(negedge pxclk);
        checkOutput("reset_small", {2'b00, s_out},
                    {2'b00, packOut(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, 8'd0)});
        checkOutput("reset_full", {2'b00, lcd_f.hsync_o, lcd_f.vsync_o, lcd_f.den_o,
                    lcd_f.col_o, lcd_f.lin_o, lcd_f.sof_o, lcd_f.frame_o},
                    {2'b00, packOut(1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 1'b0, 8'd0)});

        // Release between edges; sample k shows raster index k-1
        applyStimulus(1'b1, 1'b0);
        chk_en   = 1'b1;
        den_cnt  = 0;
        hs_cnt   = 0;
        first_hs = 0;
        rise1    = 0;
        rise2    = 0;
        prev_den = 1'b0;
        for (int k = 1; k <= 530; k++) begin
            @(negedge pxclk);
            case (k)
                1:   checkOutput("first_px", {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b1, 9'd0, 9'd0, 1'b1, 8'd1)});
                8:   checkOutput("last_col", {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b1, 9'd7, 9'd0, 1'b0, 8'd1)});
                9:   checkOutput("h_fp",     {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, 8'd1)});
                11:  checkOutput("hs_start", {2'b00, s_out}, {2'b00, packOut(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, 8'd1)});
                14:  checkOutput("hs_end",   {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, 8'd1)});
                16:  checkOutput("line1",    {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b1, 9'd0, 9'd1, 1'b0, 8'd1)});
                75:  checkOutput("v_fp_end", {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, 8'd1)});
                76:  checkOutput("vs_start", {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 1'b0, 8'd1)});
                106: checkOutput("vs_end",   {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0, 8'd1)});
                121: checkOutput("frame2",   {2'b00, s_out}, {2'b00, packOut(1'b1, 1'b0, 1'b1, 9'd0, 9'd0, 1'b1, 8'd2)});
                default: ;
            endcase
            if (k <= 525) begin
                if (lcd_f.den_o) den_cnt++;
                if (!lcd_f.hsync_o) begin
                    hs_cnt++;
                    if (first_hs == 0) first_hs = k;
                end
            end
            if (lcd_f.den_o && !prev_den) begin
                if (rise1 == 0) rise1 = k;
                else if (rise2 == 0) rise2 = k;
            end
            prev_den = lcd_f.den_o;
        end
        checkOutput("full_den_len",   den_cnt,          32'd480);
        checkOutput("full_hs_len",    hs_cnt,           32'd41);
        checkOutput("full_hs_offset", first_hs - rise1, 32'd482);
        checkOutput("full_line_per",  rise2 - rise1,    32'd525);

        // Restart mid-picture while (5,2) is on the pins
        waitModelPos(6, 2, 200, "restart_mid");
        restartCheck("restart_mid", 1);
        // Restart on the edge where the pixel counter wraps
        waitModelPos(S_HT - 1, -1, 200, "restart_hwrap");
        restartCheck("restart_hwrap", 1);
        // Restart on the edge where both counters wrap
        waitModelPos(S_HT - 1, S_VT - 1, 200, "restart_vwrap");
        restartCheck("restart_vwrap", 1);
        // Restart held for several edges
        restartCheck("restart_hold", 3);

        // One frame from this sof: 8x4 visible pixels and a single sof
        s_den = 0;
        s_sof = 0;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            if (lcd_s.den_o) s_den++;
            if (lcd_s.sof_o) s_sof++;
            @(negedge pxclk);
        end
        checkOutput("frame_den_cnt", s_den, 32'd32);
        checkOutput("frame_sof_cnt", s_sof, 32'd1);

        // Frame counter wrap 255 -> 0
        found = 1'b0;
        for (int i = 0; i < 256 * S_HT * S_VT + 2 * S_HT * S_VT && !found; i++) begin
            @(negedge pxclk);
            if (lcd_s.sof_o && lcd_s.frame_o == 8'd255) found = 1'b1;
        end
        checkOutput("frame_255_reached", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
            @(negedge pxclk);
            if (lcd_s.sof_o) found = 1'b1;
        end
        checkOutput("frame_wrap_sof", {31'd0, found}, 32'd1);
        checkOutput("frame_wrap", {24'd0, lcd_s.frame_o}, 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
